// File: rtl/icache_tag_pkg.sv
// Shared types and helpers for the instruction-cache tag sequencer.
// The state encoding and way-index width are common to the interface, top and victim selector.
package icache_tag_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } tag_state_e;

  // Keeps index vectors at least one bit wide even for degenerate way counts.
  function automatic int way_idx_width(input int nb_ways);
    return (nb_ways > 1) ? $clog2(nb_ways) : 1;
  endfunction

endpackage

// File: rtl/icache_tag_lookup_ctrl_if.sv
// Request-side bundle of the tag sequencer: flush, lookup and refill handshakes.
// Signal names are from the controller's point of view; the fetch unit uses the master modport.
interface icache_tag_lookup_ctrl_if #(
  parameter int NB_WAYS      = 4,
  parameter int SET_ID_WIDTH = 5,
  parameter int TAG_WIDTH    = 9,
  parameter int ADDR_WIDTH   = 32
);
  localparam int WAY_W = icache_tag_pkg::way_idx_width(NB_WAYS);

  logic                    flush_req_i;
  logic                    flush_ack_o;
  logic                    lkp_req_i;
  logic [ADDR_WIDTH-1:0]   lkp_addr_i;
  logic                    lkp_gnt_o;
  logic                    lkp_rvalid_o;
  logic                    lkp_hit_o;
  logic [WAY_W-1:0]        lkp_way_o;
  logic                    refill_req_i;
  logic [WAY_W-1:0]        refill_way_i;
  logic [SET_ID_WIDTH-1:0] refill_set_i;
  logic [TAG_WIDTH-1:0]    refill_tag_i;
  logic                    refill_gnt_o;

  modport master (
    output flush_req_i, lkp_req_i, lkp_addr_i,
    output refill_req_i, refill_way_i, refill_set_i, refill_tag_i,
    input  flush_ack_o, lkp_gnt_o, lkp_rvalid_o, lkp_hit_o, lkp_way_o, refill_gnt_o
  );

  modport slave (
    input  flush_req_i, lkp_req_i, lkp_addr_i,
    input  refill_req_i, refill_way_i, refill_set_i, refill_tag_i,
    output flush_ack_o, lkp_gnt_o, lkp_rvalid_o, lkp_hit_o, lkp_way_o, refill_gnt_o
  );
endinterface

// File: rtl/icache_tag_victim_sel.sv
// Picks the way to replace on a miss: lowest invalid way, otherwise the round-robin pointer.
module icache_tag_victim_sel
  import icache_tag_pkg::*;
#(
  parameter int NB_WAYS = 4,
  localparam int WAY_W  = way_idx_width(NB_WAYS)
) (
  input  logic [NB_WAYS-1:0] valid_i,
  input  logic [WAY_W-1:0]   rr_ptr_i,
  output logic [WAY_W-1:0]   victim_o,
  output logic               all_valid_o
);

  // Scanning downwards leaves the lowest invalid index as the final assignment.
  always_comb begin
    all_valid_o = &valid_i;
    victim_o    = rr_ptr_i;
    for (int i = NB_WAYS - 1; i >= 0; i--) begin
      if (!valid_i[i]) victim_o = WAY_W'(i);
    end
  end

endmodule

// File: rtl/icache_tag_lookup_ctrl.sv
// Tag-array sequencer: invalidation sweeps, lookups with hit compare, victim choice and refill writes.
module icache_tag_lookup_ctrl
  import icache_tag_pkg::*;
#(
  parameter int NB_WAYS      = 4,
  parameter int SET_ID_WIDTH = 5,
  parameter int TAG_WIDTH    = 9,
  parameter int OFFSET_WIDTH = 4,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  icache_tag_lookup_ctrl_if.slave           bus,
  output logic [NB_WAYS-1:0]                tag_req_o,
  output logic                              tag_write_o,
  output logic [SET_ID_WIDTH-1:0]           tag_addr_o,
  output logic [TAG_WIDTH:0]                tag_wdata_o,
  input  logic [NB_WAYS*(TAG_WIDTH+1)-1:0]  tag_rdata_i
);

  localparam int WAY_W = way_idx_width(NB_WAYS);
  localparam logic [SET_ID_WIDTH-1:0] LAST_SET = '1;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
  } tag_entry_t;

  tag_state_e              state_q, state_d;
  logic [SET_ID_WIDTH-1:0] cnt_q, cnt_d;
  logic                    ack_q, ack_d;
  logic                    rvalid_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [WAY_W-1:0]        rr_q;
  logic                    lkp_gnt, refill_gnt;
  logic [NB_WAYS-1:0]      hits, valids;
  logic [WAY_W-1:0]        hit_way, victim;
  logic                    any_hit, all_valid, rvalid;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^bus.lkp_addr_i;

  // A flush behaves like the first sweep cycle from either state, so set 0 is written immediately.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack_d       = 1'b0;
    tag_req_o   = '0;
    tag_write_o = 1'b0;
    tag_addr_o  = '0;
    tag_wdata_o = '0;
    lkp_gnt     = 1'b0;
    refill_gnt  = 1'b0;
    if (!rst) begin
      if (bus.flush_req_i) begin
        tag_req_o   = '1;
        tag_write_o = 1'b1;
        cnt_d       = SET_ID_WIDTH'(1);
        state_d     = INIT;
      end else begin
        case (state_q)
          INIT: begin
            tag_req_o   = '1;
            tag_write_o = 1'b1;
            tag_addr_o  = cnt_q;
            cnt_d       = cnt_q + SET_ID_WIDTH'(1);
            if (cnt_q == LAST_SET) begin
              state_d = IDLE;
              ack_d   = 1'b1;
            end
          end
          IDLE: begin
            if (bus.refill_req_i) begin
              refill_gnt  = 1'b1;
              tag_req_o   = NB_WAYS'(1) << bus.refill_way_i;
              tag_write_o = 1'b1;
              tag_addr_o  = bus.refill_set_i;
              tag_wdata_o = {1'b1, bus.refill_tag_i};
            end else if (bus.lkp_req_i) begin
              lkp_gnt    = 1'b1;
              tag_req_o  = '1;
              tag_addr_o = bus.lkp_addr_i[OFFSET_WIDTH +: SET_ID_WIDTH];
            end
          end
          default: state_d = INIT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      rvalid_q <= 1'b0;
      tag_q    <= '0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      rvalid_q <= lkp_gnt;
      if (lkp_gnt) tag_q <= bus.lkp_addr_i[OFFSET_WIDTH+SET_ID_WIDTH +: TAG_WIDTH];
      if (rvalid_q && !any_hit && all_valid) rr_q <= rr_q + WAY_W'(1);
    end
  end

  // Read data arrives the cycle after the grant; lowest hitting way wins.
  always_comb begin
    tag_entry_t entry;
    hit_way = '0;
    for (int w = 0; w < NB_WAYS; w++) begin
      entry     = tag_rdata_i[w*(TAG_WIDTH+1) +: TAG_WIDTH+1];
      valids[w] = entry.valid;
      hits[w]   = entry.valid && (entry.tag == tag_q);
    end
    for (int w = NB_WAYS - 1; w >= 0; w--) begin
      if (hits[w]) hit_way = WAY_W'(w);
    end
  end

  assign any_hit = |hits;

  icache_tag_victim_sel #(.NB_WAYS(NB_WAYS)) u_victim_sel (
    .valid_i     (valids),
    .rr_ptr_i    (rr_q),
    .victim_o    (victim),
    .all_valid_o (all_valid)
  );

  assign rvalid           = rvalid_q && !rst;
  assign bus.lkp_rvalid_o = rvalid;
  assign bus.lkp_hit_o    = rvalid && any_hit;
  assign bus.lkp_way_o    = !rvalid ? '0 : (any_hit ? hit_way : victim);
  assign bus.lkp_gnt_o    = lkp_gnt;
  assign bus.refill_gnt_o = refill_gnt;
  assign bus.flush_ack_o  = ack_q && !rst;

  a_single_hit: assert property (@(posedge clk) disable iff (rst) rvalid_q |-> $onehot0(hits));

endmodule

// File: tb/tb_icache_tag_lookup_ctrl.sv
// Scoreboard bench: a reference tag model predicts each lookup result at grant time.
module tb_icache_tag_lookup_ctrl;

  localparam int NB_WAYS = 4;
  localparam int SET_W   = 5;
  localparam int TAG_W   = 9;
  localparam int OFF_W   = 4;
  localparam int ADDR_W  = 32;
  localparam int NB_SETS = 32;
  localparam int ENT_W   = TAG_W + 1;

  typedef struct packed {
    logic       hit;
    logic [1:0] way;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_tag_lookup_ctrl_if #(
    .NB_WAYS(NB_WAYS), .SET_ID_WIDTH(SET_W), .TAG_WIDTH(TAG_W), .ADDR_WIDTH(ADDR_W)
  ) bus ();

  logic [NB_WAYS-1:0]       tagReq;
  logic                     tagWrite;
  logic [SET_W-1:0]         tagAddr;
  logic [ENT_W-1:0]         tagWdata;
  logic [NB_WAYS*ENT_W-1:0] tagRdata;

  icache_tag_lookup_ctrl #(
    .NB_WAYS(NB_WAYS), .SET_ID_WIDTH(SET_W), .TAG_WIDTH(TAG_W),
    .OFFSET_WIDTH(OFF_W), .ADDR_WIDTH(ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .tag_req_o   (tagReq),
    .tag_write_o (tagWrite),
    .tag_addr_o  (tagAddr),
    .tag_wdata_o (tagWdata),
    .tag_rdata_i (tagRdata)
  );

  // Behavioural per-way tag RAMs with one-cycle read latency.
  logic [ENT_W-1:0] ram [NB_WAYS][NB_SETS];
  always @(posedge clk) begin
    for (int w = 0; w < NB_WAYS; w++) begin
      if (tagReq[w]) begin
        if (tagWrite) ram[w][tagAddr] <= tagWdata;
        else tagRdata[w*ENT_W +: ENT_W] <= ram[w][tagAddr];
      end
    end
  end

  logic             mValid [NB_WAYS][NB_SETS];
  logic [TAG_W-1:0] mTag   [NB_WAYS][NB_SETS];
  int               mRr;
  exp_t             sbq[$];
  int               nChecks = 0;
  int               nPassed = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPassed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic clearModel();
    for (int w = 0; w < NB_WAYS; w++)
      for (int s = 0; s < NB_SETS; s++) mValid[w][s] = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] mkAddr(input int set, input int tag);
    logic [ADDR_W-1:0] a;
    a = $urandom;
    a[OFF_W +: SET_W] = SET_W'(set);
    a[OFF_W+SET_W +: TAG_W] = TAG_W'(tag);
    return a;
  endfunction

  task automatic predictPush(input logic [ADDR_W-1:0] a);
    int s, inv;
    logic [TAG_W-1:0] t;
    exp_t e;
    s = int'(a[OFF_W +: SET_W]);
    t = a[OFF_W+SET_W +: TAG_W];
    e = '0;
    inv = -1;
    for (int w = 0; w < NB_WAYS; w++) begin
      if (!e.hit && mValid[w][s] && mTag[w][s] == t) begin
        e.hit = 1'b1;
        e.way = 2'(w);
      end
      if (inv < 0 && !mValid[w][s]) inv = w;
    end
    if (!e.hit) begin
      if (inv >= 0) e.way = 2'(inv);
      else begin
        e.way = 2'(mRr);
        mRr = (mRr + 1) % NB_WAYS;
      end
    end
    sbq.push_back(e);
  endtask

  task automatic sampleCycle();
    exp_t e;
    if (rst) begin
      sbq.delete();
      clearModel();
      mRr = 0;
    end else begin
      if (bus.lkp_rvalid_o) begin
        if (sbq.size() == 0) checkOutput("rvalid_unexpected", 1, 0);
        else begin
          e = sbq.pop_front();
          checkOutput("lkp_hit", 32'(bus.lkp_hit_o), 32'(e.hit));
          checkOutput("lkp_way", 32'(bus.lkp_way_o), 32'(e.way));
        end
      end else begin
        checkOutput("idle_result", {bus.lkp_hit_o, bus.lkp_way_o}, 0);
        if (sbq.size() != 0) begin
          checkOutput("rvalid_missing", 0, 1);
          sbq.delete();
        end
      end
      if (bus.flush_req_i) clearModel();
      else if (bus.refill_gnt_o) begin
        mValid[bus.refill_way_i][bus.refill_set_i] = 1'b1;
        mTag[bus.refill_way_i][bus.refill_set_i]   = bus.refill_tag_i;
      end
      if (bus.lkp_gnt_o) predictPush(bus.lkp_addr_i);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic flush, input logic lkpReq,
                               input logic [ADDR_W-1:0] lkpAddr, input logic refReq,
                               input int refWay, input int refSet, input int refTag);
    @(negedge clk);
    rst              = r;
    bus.flush_req_i  = flush;
    bus.lkp_req_i    = lkpReq;
    bus.lkp_addr_i   = lkpAddr;
    bus.refill_req_i = refReq;
    bus.refill_way_i = 2'(refWay);
    bus.refill_set_i = SET_W'(refSet);
    bus.refill_tag_i = TAG_W'(refTag);
    #1;
    sampleCycle();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 0, 0, 0);
  endtask

  task automatic lookup(input logic [ADDR_W-1:0] a);
    applyStimulus(1'b0, 1'b0, 1'b1, a, 1'b0, 0, 0, 0);
  endtask

  task automatic refill(input int w, input int s, input int t);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, w, s, t);
  endtask

  function automatic logic [31:0] sweepVec();
    return 32'({tagReq, tagWrite, tagAddr, tagWdata, bus.lkp_gnt_o, bus.refill_gnt_o, bus.flush_ack_o});
  endfunction

  function automatic logic [31:0] sweepExp(input int k);
    return 32'({4'hF, 1'b1, SET_W'(k), 10'h000, 3'b000});
  endfunction

  task automatic checkReset(input string name);
    applyStimulus(1'b1, 1'b1, 1'b1, mkAddr(1, 1), 1'b1, 1, 1, 1);
    checkOutput(name, 32'({tagReq, tagWrite, tagAddr, tagWdata, bus.lkp_gnt_o, bus.refill_gnt_o,
                           bus.flush_ack_o, bus.lkp_rvalid_o, bus.lkp_hit_o, bus.lkp_way_o}), 0);
  endtask

  // A lookup is held during sweeps to show it is never granted there.
  task automatic sweepCycles(input string name, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, mkAddr(3, 0), 1'b0, 0, 0, 0);
      checkOutput(name, sweepVec(), sweepExp(k));
    end
  endtask

  task automatic ackCheck(input string name);
    applyStimulus(1'b0, 1'b0, 1'b1, mkAddr(3, 0), 1'b0, 0, 0, 0);
    checkOutput(name, 32'({bus.flush_ack_o, bus.lkp_gnt_o}), 32'b11);
    idle();
    checkOutput({name, "_pulse_end"}, 32'(bus.flush_ack_o), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.flush_req_i  = 1'b0;
    bus.lkp_req_i    = 1'b0;
    bus.lkp_addr_i   = '0;
    bus.refill_req_i = 1'b0;
    bus.refill_way_i = '0;
    bus.refill_set_i = '0;
    bus.refill_tag_i = '0;
    mRr = 0;
    clearModel();

    repeat (3) checkReset("reset_outputs");
    sweepCycles("reset_sweep", 0, NB_SETS - 1);
    ackCheck("reset_ack");

    refill(2, 5, 'h1A5);
    checkOutput("refill_bus", 32'({bus.refill_gnt_o, bus.lkp_gnt_o, tagReq, tagWrite, tagAddr, tagWdata}),
                32'({1'b1, 1'b0, 4'b0100, 1'b1, 5'd5, 10'h3A5}));
    lookup(mkAddr(5, 'h1A5));
    checkOutput("lookup_bus", 32'({bus.lkp_gnt_o, bus.refill_gnt_o, tagReq, tagWrite, tagAddr}),
                32'({1'b1, 1'b0, 4'hF, 1'b0, 5'd5}));
    lookup(mkAddr(5, 'h0F0));
    idle();
    idle();

    for (int w = 0; w < NB_WAYS; w++) refill(w, 3, 'h100 + w);
    for (int i = 0; i < 5; i++) lookup(mkAddr(3, 'h055));
    idle();

    applyStimulus(1'b0, 1'b0, 1'b1, mkAddr(7, 'h77), 1'b1, 1, 7, 'h77);
    checkOutput("prio_refill_over_lookup", 32'({bus.refill_gnt_o, bus.lkp_gnt_o}), 32'b10);
    lookup(mkAddr(7, 'h77));
    checkOutput("lookup_after_refill_gnt", 32'(bus.lkp_gnt_o), 1);
    idle();

    lookup(mkAddr(5, 'h1A5));
    applyStimulus(1'b0, 1'b1, 1'b1, mkAddr(5, 'h1A5), 1'b1, 0, 0, 0);
    checkOutput("flush_from_idle", sweepVec(), sweepExp(0));
    sweepCycles("flush_sweep", 1, 10 - 1);
    applyStimulus(1'b0, 1'b1, 1'b1, mkAddr(5, 'h1A5), 1'b0, 0, 0, 0);
    checkOutput("flush_restart", sweepVec(), sweepExp(0));
    sweepCycles("restart_sweep", 1, NB_SETS - 1);
    ackCheck("restart_ack");

    lookup(mkAddr(5, 'h1A5));
    checkReset("reset_mid_lookup");
    checkReset("reset_hold");
    sweepCycles("sweep_before_reset", 0, 4);
    checkReset("reset_mid_sweep");
    sweepCycles("sweep_after_reset", 0, NB_SETS - 1);
    ackCheck("final_ack");
    idle();
    checkOutput("scoreboard_drained", 32'(sbq.size()), 0);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
